// File: rtl/instr_loader.sv
// Byte-stream writer for the instruction ROM: accepts bytes over valid/ready,
// writes them from address 0 and stops on an all-zero word or a full memory.
module instr_loader #(
  parameter int SIZE  = 256,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  output logic             in_ready,
  output logic             wr_en,
  output logic [7:0]       wr_addr,
  output logic [7:0]       wr_data,
  output logic [CNT_W-1:0] words_loaded,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  localparam logic [7:0] LAST_ADDR = 8'(SIZE - 1);

  state_t      state;
  logic [7:0]  addr;
  logic [1:0]  lane;
  logic [23:0] shadow;
  logic        accept;
  logic [31:0] word;

  assign in_ready = (state == LOAD);
  assign accept   = in_valid && in_ready;
  // The word is only complete at lane 3, so the top byte comes straight from the input.
  assign word     = {in_byte, shadow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      addr         <= 8'd0;
      lane         <= 2'd0;
      shadow       <= 24'd0;
      wr_en        <= 1'b0;
      wr_addr      <= 8'd0;
      wr_data      <= 8'd0;
      words_loaded <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= LOAD;
            addr         <= 8'd0;
            lane         <= 2'd0;
            shadow       <= 24'd0;
            words_loaded <= '0;
            overflow     <= 1'b0;
            busy         <= 1'b1;
            done         <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            wr_en   <= 1'b1;
            wr_addr <= addr;
            wr_data <= in_byte;
            addr    <= addr + 8'd1;
            lane    <= lane + 2'd1;
            case (lane)
              2'd0: shadow[7:0]   <= in_byte;
              2'd1: shadow[15:8]  <= in_byte;
              2'd2: shadow[23:16] <= in_byte;
              default: begin
                if (word == 32'h0) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end else begin
                  words_loaded <= words_loaded + CNT_W'(1);
                  if (addr == LAST_ADDR) begin
                    overflow <= 1'b1;
                    state    <= DONE;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                  end
                end
              end
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: a default-size loader and a 16-byte loader
// share one byte stream so the full-memory case can be exercised alongside.
module tb_instr_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic [7:0] in_byte;

  logic       in_ready, wr_en, busy, done, overflow;
  logic [7:0] wr_addr, wr_data;
  logic [6:0] words_loaded;

  logic       s_in_ready, s_wr_en, s_busy, s_done, s_overflow;
  logic [7:0] s_wr_addr, s_wr_data;
  logic [6:0] s_words_loaded;

  int checks = 0;
  int errors = 0;

  logic [7:0] prog [12] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
                            8'h00, 8'h00, 8'h00, 8'h00};

  instr_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .words_loaded(words_loaded), .busy(busy), .done(done), .overflow(overflow)
  );

  instr_loader #(.SIZE(16), .CNT_W(7)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(s_in_ready), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .words_loaded(s_words_loaded), .busy(s_busy), .done(s_done), .overflow(s_overflow)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  // Present one byte, then confirm the write lands exactly one edge later.
  task automatic send_byte(input logic [7:0] b, input logic [7:0] a);
    in_valid = 1'b1;
    in_byte  = b;
    check_output("in_ready", in_ready, 1);
    @(posedge clk); #1;
    check_output("wr_en", wr_en, 1);
    check_output("wr_addr", wr_addr, a);
    check_output("wr_data", wr_data, b);
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_output("wr_en idle", wr_en, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_output("busy after start", busy, 1);
    check_output("done after start", done, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
    #1;
    $display("[TB] reset state");
    check_output("rst in_ready", in_ready, 0);
    check_output("rst wr_en", wr_en, 0);
    check_output("rst wr_addr", wr_addr, 0);
    check_output("rst wr_data", wr_data, 0);
    check_output("rst words", words_loaded, 0);
    check_output("rst busy", busy, 0);
    check_output("rst done", done, 0);
    check_output("rst overflow", overflow, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] normal load");
    pulse_start();
    for (int i = 0; i < 12; i++) send_byte(prog[i], 8'(i));
    check_output("normal done", done, 1);
    check_output("normal busy", busy, 0);
    check_output("normal in_ready", in_ready, 0);
    check_output("normal words", words_loaded, 2);
    check_output("normal overflow", overflow, 0);
    in_valid = 1'b1;
    idle_cycle();
    check_output("done holds", done, 1);
    check_output("wr_addr holds", wr_addr, 11);

    $display("[TB] gapped load with ignored start");
    pulse_start();
    for (int i = 0; i < 12; i++) begin
      send_byte(prog[i], 8'(i));
      if (i < 11) begin
        if (i == 5) start = 1'b1;
        idle_cycle();
        start = 1'b0;
      end
    end
    check_output("gap done", done, 1);
    check_output("gap words", words_loaded, 2);

    $display("[TB] embedded zero bytes");
    pulse_start();
    send_byte(8'h00, 8'd0);
    send_byte(8'h00, 8'd1);
    send_byte(8'h00, 8'd2);
    send_byte(8'h01, 8'd3);
    check_output("zero-byte word not terminator", done, 0);
    check_output("zero-byte words", words_loaded, 1);
    for (int i = 4; i < 8; i++) send_byte(8'h00, 8'(i));
    check_output("zero-byte done", done, 1);
    check_output("zero-byte words final", words_loaded, 1);

    $display("[TB] reset mid-load");
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(8'(8'hA0 + i), 8'(i));
    check_output("pre-reset words", words_loaded, 1);
    #2 rst_n = 1'b0;
    #1;
    check_output("mid rst wr_en", wr_en, 0);
    check_output("mid rst wr_addr", wr_addr, 0);
    check_output("mid rst wr_data", wr_data, 0);
    check_output("mid rst words", words_loaded, 0);
    check_output("mid rst busy", busy, 0);
    check_output("mid rst in_ready", in_ready, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(8'h00, 8'(i));
    check_output("term-only done", done, 1);
    check_output("term-only words", words_loaded, 0);
    check_output("term-only overflow", overflow, 0);

    $display("[TB] full memory on 16-byte loader");
    pulse_start();
    for (int i = 0; i < 16; i++) send_byte(8'(8'h11 + i), 8'(i));
    check_output("full done", s_done, 1);
    check_output("full overflow", s_overflow, 1);
    check_output("full words", s_words_loaded, 4);
    check_output("full last addr", s_wr_addr, 15);
    check_output("full busy", s_busy, 0);
    check_output("big still loading", done, 0);
    check_output("big words", words_loaded, 4);
    in_valid = 1'b1;
    check_output("17th in_ready", s_in_ready, 0);
    for (int i = 16; i < 20; i++) begin
      send_byte(8'h00, 8'(i));
      check_output("full no write", s_wr_en, 0);
    end
    check_output("big terminated", done, 1);
    check_output("big words final", words_loaded, 4);
    check_output("full addr held", s_wr_addr, 15);

    $display("[TB] restart from DONE");
    pulse_start();
    check_output("restart overflow cleared", s_overflow, 0);
    check_output("restart words cleared", s_words_loaded, 0);
    send_byte(8'h01, 8'd0);
    send_byte(8'h02, 8'd1);
    send_byte(8'h03, 8'd2);
    send_byte(8'h04, 8'd3);
    for (int i = 4; i < 8; i++) send_byte(8'h00, 8'(i));
    check_output("restart done", done, 1);
    check_output("restart words", words_loaded, 1);
    check_output("restart small done", s_done, 1);
    check_output("restart small overflow", s_overflow, 0);
    check_output("restart small words", s_words_loaded, 1);
    check_output("restart small addr", s_wr_addr, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
